// File: rtl/decode_stage_pkg.sv
// Shared constants for the decode stage: RV32I opcodes, instruction field
// positions and the decoded control bundle.
package decode_stage_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ROB_ID_W_DEF = 4;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_B      = 7'b1100011;
    localparam logic [6:0] OPCODE_L      = 7'b0000011;
    localparam logic [6:0] OPCODE_S      = 7'b0100011;
    localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int FUNC3_MSB  = 14;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC1_BIT  = 30;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;

    typedef struct packed {
        logic to_rs;
        logic to_lsb;
        logic use_rs1;
        logic use_rs2;
        logic rd_valid;
        logic is_branch;
        logic is_store;
    } dec_ctl_t;

endpackage

// File: rtl/decode_stage_inst_fifo.sv
// Synchronous instruction FIFO; a push is accepted at full when a pop
// happens in the same cycle. Pointers wrap naturally (BUF_DEPTH is 2^n).
module decode_stage_inst_fifo #(
    parameter int BUF_DEPTH = 4,
    parameter int WIDTH     = 65
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(BUF_DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (do_push) wptr_q <= wptr_q + 1'b1;
                if (do_pop)  rptr_q <= rptr_q + 1'b1;
                cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (en_i && !flush_i && do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: buffers fetched instructions, decodes the FIFO head, resolves
// operands and holds one packet for dispatch while snooping the CDB.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CDB_N     = 2,
    parameter int ROB_ID_W  = ROB_ID_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic                      inst_valid,
    input  logic [DATA_W-1:0]         inst,
    input  logic [DATA_W-1:0]         inst_pc,
    input  logic                      inst_predict_jump,
    output logic                      inst_ready,
    output logic [4:0]                rf_rs1,
    output logic [4:0]                rf_rs2,
    input  logic [DATA_W-1:0]         rf_rs1_data,
    input  logic                      rf_rs1_busy,
    input  logic [ROB_ID_W-1:0]       rf_rs1_rob_id,
    input  logic [DATA_W-1:0]         rf_rs2_data,
    input  logic                      rf_rs2_busy,
    input  logic [ROB_ID_W-1:0]       rf_rs2_rob_id,
    output logic [ROB_ID_W-1:0]       rob_q1_id,
    input  logic                      rob_q1_ready,
    input  logic [DATA_W-1:0]         rob_q1_data,
    output logic [ROB_ID_W-1:0]       rob_q2_id,
    input  logic                      rob_q2_ready,
    input  logic [DATA_W-1:0]         rob_q2_data,
    input  logic [ROB_ID_W-1:0]       rob_alloc_id,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_to_rs,
    output logic                      out_to_lsb,
    output logic [6:0]                out_opcode,
    output logic [2:0]                out_func3,
    output logic                      out_func1,
    output logic                      out_rs1_dep,
    output logic [ROB_ID_W-1:0]       out_rs1_rob_id,
    output logic [DATA_W-1:0]         out_rs1_data,
    output logic                      out_rs2_dep,
    output logic [ROB_ID_W-1:0]       out_rs2_rob_id,
    output logic [DATA_W-1:0]         out_rs2_data,
    output logic                      out_rd_valid,
    output logic [4:0]                out_rd,
    output logic [ROB_ID_W-1:0]       out_rd_rob_id,
    output logic [DATA_W-1:0]         out_imm,
    output logic [DATA_W-1:0]         out_pc,
    output logic                      out_is_branch,
    output logic                      out_predict_jump,
    output logic                      out_is_store
);
    localparam int ENT_W = 2*DATA_W + 1;

    function automatic dec_ctl_t decode_ctl(input logic [6:0] op);
        dec_ctl_t c;
        c          = '0;
        c.to_rs    = 1'b1;
        c.rd_valid = 1'b1;
        case (op)
            OPCODE_ARITH:  begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OPCODE_ARITHI: c.use_rs1 = 1'b1;
            OPCODE_L:      begin c.use_rs1 = 1'b1; c.to_rs = 1'b0; c.to_lsb = 1'b1; end
            OPCODE_S: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.to_rs = 1'b0;
                c.to_lsb = 1'b1; c.rd_valid = 1'b0; c.is_store = 1'b1;
            end
            OPCODE_B: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
                c.rd_valid = 1'b0; c.is_branch = 1'b1;
            end
            OPCODE_JAL, OPCODE_JALR: c.is_branch = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] i);
        logic [31:0] r;
        r = '0;
        case (i[6:0])
            OPCODE_LUI, OPCODE_AUIPC: r = {i[31:12], 12'b0};
            OPCODE_JAL:  r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OPCODE_B:    r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPCODE_ARITHI, OPCODE_L, OPCODE_JALR: r = {{20{i[31]}}, i[31:20]};
            OPCODE_S:    r = {{20{i[31]}}, i[31:25], i[11:7]};
            default:     r = '0;
        endcase
        return r;
    endfunction

    // Lowest-indexed matching channel wins, hence the descending scan.
    function automatic void cdb_match(
        input  logic [ROB_ID_W-1:0]       id,
        input  logic [CDB_N-1:0]          v,
        input  logic [CDB_N*ROB_ID_W-1:0] ids,
        input  logic [CDB_N*DATA_W-1:0]   d,
        output logic                      hit,
        output logic [DATA_W-1:0]         data
    );
        hit  = 1'b0;
        data = '0;
        for (int i = CDB_N-1; i >= 0; i--) begin
            if (v[i] && ids[i*ROB_ID_W +: ROB_ID_W] == id) begin
                hit  = 1'b1;
                data = d[i*DATA_W +: DATA_W];
            end
        end
    endfunction

    logic [ENT_W-1:0]    head;
    logic [DATA_W-1:0]   head_inst, head_pc;
    logic                head_pred, fifo_full, fifo_empty, push, pop, fire;
    dec_ctl_t            ctl_d, ctl_q;
    logic                valid_q, func1_q, pred_q;
    logic [6:0]          opcode_q;
    logic [2:0]          func3_q;
    logic [4:0]          rd_q;
    logic [ROB_ID_W-1:0] rd_rob_id_q;
    logic [DATA_W-1:0]   imm_q, pc_q;
    logic                rs1_dep_q, rs2_dep_q, rs1_dep_d, rs2_dep_d;
    logic [ROB_ID_W-1:0] rs1_rob_id_q, rs2_rob_id_q, rs1_rob_id_d, rs2_rob_id_d;
    logic [DATA_W-1:0]   rs1_data_q, rs2_data_q, rs1_data_d, rs2_data_d;
    logic                hit1_l, hit2_l, hit1_h, hit2_h;
    logic [DATA_W-1:0]   cd1_l, cd2_l, cd1_h, cd2_h;

    assign push = inst_valid && inst_ready;
    assign fire = valid_q && out_ready;
    assign pop  = !fifo_empty && (!valid_q || fire);

    decode_stage_inst_fifo #(.BUF_DEPTH(BUF_DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk     (clk),
        .rst_n_i (rst),
        .en_i    (rdy),
        .flush_i (rollback),
        .push_i  (push),
        .wdata_i ({inst_predict_jump, inst_pc, inst}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign inst_ready = !fifo_full;
    assign head_inst  = head[DATA_W-1:0];
    assign head_pc    = head[2*DATA_W-1:DATA_W];
    assign head_pred  = head[2*DATA_W];
    assign rf_rs1     = head_inst[RS1_MSB:RS1_LSB];
    assign rf_rs2     = head_inst[RS2_MSB:RS2_LSB];
    assign rob_q1_id  = rf_rs1_rob_id;
    assign rob_q2_id  = rf_rs2_rob_id;
    assign ctl_d      = decode_ctl(head_inst[OPCODE_MSB:OPCODE_LSB]);

    always_comb begin
        cdb_match(rf_rs1_rob_id, cdb_valid, cdb_rob_id, cdb_data, hit1_l, cd1_l);
        cdb_match(rf_rs2_rob_id, cdb_valid, cdb_rob_id, cdb_data, hit2_l, cd2_l);
        cdb_match(rs1_rob_id_q,  cdb_valid, cdb_rob_id, cdb_data, hit1_h, cd1_h);
        cdb_match(rs2_rob_id_q,  cdb_valid, cdb_rob_id, cdb_data, hit2_h, cd2_h);

        rs1_dep_d = 1'b0; rs1_rob_id_d = '0; rs1_data_d = '0;
        if (!ctl_d.use_rs1 || rf_rs1 == 5'd0) rs1_data_d = '0;
        else if (!rf_rs1_busy)                rs1_data_d = rf_rs1_data;
        else if (rob_q1_ready)                rs1_data_d = rob_q1_data;
        else if (hit1_l)                      rs1_data_d = cd1_l;
        else begin rs1_dep_d = 1'b1; rs1_rob_id_d = rf_rs1_rob_id; end

        rs2_dep_d = 1'b0; rs2_rob_id_d = '0; rs2_data_d = '0;
        if (!ctl_d.use_rs2 || rf_rs2 == 5'd0) rs2_data_d = '0;
        else if (!rf_rs2_busy)                rs2_data_d = rf_rs2_data;
        else if (rob_q2_ready)                rs2_data_d = rob_q2_data;
        else if (hit2_l)                      rs2_data_d = cd2_l;
        else begin rs2_dep_d = 1'b1; rs2_rob_id_d = rf_rs2_rob_id; end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            ctl_q        <= '0;
            opcode_q     <= '0;
            func3_q      <= '0;
            func1_q      <= 1'b0;
            rd_q         <= '0;
            rd_rob_id_q  <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            pred_q       <= 1'b0;
            rs1_dep_q    <= 1'b0;
            rs1_rob_id_q <= '0;
            rs1_data_q   <= '0;
            rs2_dep_q    <= 1'b0;
            rs2_rob_id_q <= '0;
            rs2_data_q   <= '0;
        end else if (rdy) begin
            if (rollback) begin
                valid_q <= 1'b0;
            end else if (pop) begin
                valid_q      <= 1'b1;
                ctl_q        <= ctl_d;
                opcode_q     <= head_inst[OPCODE_MSB:OPCODE_LSB];
                func3_q      <= head_inst[FUNC3_MSB:FUNC3_LSB];
                func1_q      <= head_inst[FUNC1_BIT];
                rd_q         <= head_inst[RD_MSB:RD_LSB];
                rd_rob_id_q  <= rob_alloc_id;
                imm_q        <= DATA_W'(gen_imm(head_inst[31:0]));
                pc_q         <= head_pc;
                pred_q       <= head_pred;
                rs1_dep_q    <= rs1_dep_d;
                rs1_rob_id_q <= rs1_rob_id_d;
                rs1_data_q   <= rs1_data_d;
                rs2_dep_q    <= rs2_dep_d;
                rs2_rob_id_q <= rs2_rob_id_d;
                rs2_data_q   <= rs2_data_d;
            end else if (fire) begin
                valid_q <= 1'b0;
            end else if (valid_q) begin
                // Stalled packet: pending operands resolve from the CDB in place.
                if (rs1_dep_q && hit1_h) begin
                    rs1_dep_q  <= 1'b0;
                    rs1_data_q <= cd1_h;
                end
                if (rs2_dep_q && hit2_h) begin
                    rs2_dep_q  <= 1'b0;
                    rs2_data_q <= cd2_h;
                end
            end
        end
    end

    assign out_valid        = valid_q;
    assign out_to_rs        = ctl_q.to_rs;
    assign out_to_lsb       = ctl_q.to_lsb;
    assign out_opcode       = opcode_q;
    assign out_func3        = func3_q;
    assign out_func1        = func1_q;
    assign out_rs1_dep      = rs1_dep_q;
    assign out_rs1_rob_id   = rs1_rob_id_q;
    assign out_rs1_data     = rs1_data_q;
    assign out_rs2_dep      = rs2_dep_q;
    assign out_rs2_rob_id   = rs2_rob_id_q;
    assign out_rs2_data     = rs2_data_q;
    assign out_rd_valid     = ctl_q.rd_valid;
    assign out_rd           = rd_q;
    assign out_rd_rob_id    = rd_rob_id_q;
    assign out_imm          = imm_q;
    assign out_pc           = pc_q;
    assign out_is_branch    = ctl_q.is_branch;
    assign out_predict_jump = pred_q;
    assign out_is_store     = ctl_q.is_store;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed packets, FIFO fill/drain,
// CDB capture while stalled and at latch, rollback, immediates.
module tb_decode_stage;
    localparam int BUF_DEPTH = 4;
    localparam int CDB_N     = 2;
    localparam int ROB_ID_W  = 4;
    localparam int DATA_W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0, rdy = 1'b1, rollback = 1'b0;
    logic inst_valid = 1'b0, inst_predict_jump = 1'b0, inst_ready;
    logic [DATA_W-1:0] inst = '0, inst_pc = '0;
    logic [4:0] rf_rs1, rf_rs2;
    logic [DATA_W-1:0] rf_rs1_data = '0, rf_rs2_data = '0;
    logic rf_rs1_busy = 1'b0, rf_rs2_busy = 1'b0;
    logic [ROB_ID_W-1:0] rf_rs1_rob_id = '0, rf_rs2_rob_id = '0;
    logic [ROB_ID_W-1:0] rob_q1_id, rob_q2_id, rob_alloc_id = '0;
    logic rob_q1_ready = 1'b0, rob_q2_ready = 1'b0;
    logic [DATA_W-1:0] rob_q1_data = '0, rob_q2_data = '0;
    logic [CDB_N-1:0] cdb_valid = '0;
    logic [CDB_N*ROB_ID_W-1:0] cdb_rob_id = '0;
    logic [CDB_N*DATA_W-1:0] cdb_data = '0;
    logic out_valid, out_ready = 1'b0, out_to_rs, out_to_lsb, out_func1;
    logic [6:0] out_opcode;
    logic [2:0] out_func3;
    logic out_rs1_dep, out_rs2_dep, out_rd_valid, out_is_branch, out_predict_jump, out_is_store;
    logic [ROB_ID_W-1:0] out_rs1_rob_id, out_rs2_rob_id, out_rd_rob_id;
    logic [DATA_W-1:0] out_rs1_data, out_rs2_data, out_imm, out_pc;
    logic [4:0] out_rd;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage #(.BUF_DEPTH(BUF_DEPTH), .CDB_N(CDB_N), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_predict_jump(inst_predict_jump), .inst_ready(inst_ready),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rs1_data(rf_rs1_data), .rf_rs1_busy(rf_rs1_busy), .rf_rs1_rob_id(rf_rs1_rob_id),
        .rf_rs2_data(rf_rs2_data), .rf_rs2_busy(rf_rs2_busy), .rf_rs2_rob_id(rf_rs2_rob_id),
        .rob_q1_id(rob_q1_id), .rob_q1_ready(rob_q1_ready), .rob_q1_data(rob_q1_data),
        .rob_q2_id(rob_q2_id), .rob_q2_ready(rob_q2_ready), .rob_q2_data(rob_q2_data),
        .rob_alloc_id(rob_alloc_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_to_rs(out_to_rs), .out_to_lsb(out_to_lsb),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_func1(out_func1),
        .out_rs1_dep(out_rs1_dep), .out_rs1_rob_id(out_rs1_rob_id), .out_rs1_data(out_rs1_data),
        .out_rs2_dep(out_rs2_dep), .out_rs2_rob_id(out_rs2_rob_id), .out_rs2_data(out_rs2_data),
        .out_rd_valid(out_rd_valid), .out_rd(out_rd), .out_rd_rob_id(out_rd_rob_id),
        .out_imm(out_imm), .out_pc(out_pc), .out_is_branch(out_is_branch),
        .out_predict_jump(out_predict_jump), .out_is_store(out_is_store)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drv(input logic [31:0] i, input logic [31:0] pc, input logic pj);
        inst_valid = 1'b1;
        inst = i;
        inst_pc = pc;
        inst_predict_jump = pj;
    endtask

    // Push one instruction into an empty stage; the packet is visible on return.
    task automatic send(input logic [31:0] i, input logic [31:0] pc, input logic pj);
        drv(i, pc, pj);
        tick;
        inst_valid = 1'b0;
        tick;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        tick;
        tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_inst_ready", inst_ready, 1);
        chk("rst_imm", out_imm, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_rd", out_rd, 0);
        rst = 1'b1;

        // ADDI x5,x0,7: x0 reads as 0, latency of two edges
        out_ready = 1'b1; rob_alloc_id = 4'd5;
        rf_rs1_data = 32'h1234; rf_rs2_data = 32'h5678;
        drv(32'h00700293, 32'h100, 1'b0);
        tick;
        inst_valid = 1'b0;
        chk("addi_latency", out_valid, 0);
        chk("addi_rf_rs2", rf_rs2, 7);
        tick;
        chk("addi_valid", out_valid, 1);
        chk("addi_imm", out_imm, 7);
        chk("addi_rs1_dep", out_rs1_dep, 0);
        chk("addi_rs1_data", out_rs1_data, 0);
        chk("addi_rs2_data", out_rs2_data, 0);
        chk("addi_rd", out_rd, 5);
        chk("addi_to_rs", out_to_rs, 1);
        chk("addi_rd_valid", out_rd_valid, 1);
        chk("addi_pc", out_pc, 32'h100);
        chk("addi_rd_rob", out_rd_rob_id, 5);
        tick;
        chk("addi_drain", out_valid, 0);

        // Fill: one packet held plus four buffered
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("fill_ready", inst_ready, 1);
            drv(addi(k, k), 32'h200 + 32'(4*k), 1'b0);
            tick;
        end
        inst_valid = 1'b0;
        chk("fill_full", inst_ready, 0);
        chk("fill_hold_imm", out_imm, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_imm", out_imm, 64'(k));
            tick;
        end
        chk("drain_end", out_valid, 0);

        // Stall capture: ADD x3,x1,x2 with rs1 pending on rob 3
        out_ready = 1'b0; rf_rs1_busy = 1'b1; rf_rs1_rob_id = 4'd3;
        rf_rs2_data = 32'h22;
        drv(32'h002081B3, 32'h300, 1'b0);
        tick;
        inst_valid = 1'b0;
        tick;
        chk("stall_valid", out_valid, 1);
        chk("stall_rs1_dep", out_rs1_dep, 1);
        chk("stall_rs1_rob", out_rs1_rob_id, 3);
        chk("stall_rs2_dep", out_rs2_dep, 0);
        chk("stall_rs2_data", out_rs2_data, 32'h22);
        chk("rob_q1_id", rob_q1_id, 3);
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd4}; cdb_data = {32'h0, 32'hBAD};
        tick;
        chk("stall_nomatch_dep", out_rs1_dep, 1);
        cdb_valid = 2'b10; cdb_rob_id = {4'd3, 4'd0}; cdb_data = {32'hDEAD, 32'h0};
        tick;
        cdb_valid = '0;
        chk("stall_cap_dep", out_rs1_dep, 0);
        chk("stall_cap_data", out_rs1_data, 32'hDEAD);
        chk("stall_cap_valid", out_valid, 1);
        out_ready = 1'b1;
        tick;
        chk("stall_drain", out_valid, 0);

        // Latch-time resolution: rs1 from ROB, rs2 from CDB (ch0 beats ch1)
        rf_rs1_busy = 1'b1; rob_q1_ready = 1'b1; rob_q1_data = 32'h77; rf_rs1_data = 32'h11;
        rf_rs2_busy = 1'b1; rf_rs2_rob_id = 4'd2;
        drv(32'h002081B3, 32'h400, 1'b0);
        tick;
        inst_valid = 1'b0;
        cdb_valid = 2'b11; cdb_rob_id = {4'd2, 4'd2}; cdb_data = {32'h66, 32'h55};
        tick;
        cdb_valid = '0;
        chk("byp_rs2_dep", out_rs2_dep, 0);
        chk("byp_rs2_data", out_rs2_data, 32'h55);
        chk("byp_rs1_dep", out_rs1_dep, 0);
        chk("byp_rs1_rob_data", out_rs1_data, 32'h77);
        tick;
        rf_rs1_busy = 1'b0; rf_rs2_busy = 1'b0; rob_q1_ready = 1'b0;

        // Rollback with three buffered entries and a concurrent push
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drv(addi(k, k), 32'h500, 1'b0);
            tick;
        end
        drv(addi(9, 99), 32'h600, 1'b0);
        rollback = 1'b1;
        tick;
        rollback = 1'b0; inst_valid = 1'b0;
        chk("rb_valid", out_valid, 0);
        chk("rb_inst_ready", inst_ready, 1);
        out_ready = 1'b1;
        tick;
        tick;
        chk("rb_dropped", out_valid, 0);
        send(addi(1, 42), 32'h700, 1'b0);
        chk("rb_after_valid", out_valid, 1);
        chk("rb_after_imm", out_imm, 42);

        // Immediates and control
        send(32'hFE000EE3, 32'h800, 1'b0);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_branch", out_is_branch, 1);
        chk("beq_rd_valid", out_rd_valid, 0);
        chk("beq_to_rs", out_to_rs, 1);
        rf_rs1_data = 32'h1000; rf_rs2_data = 32'hABC;
        send(32'h00112623, 32'h804, 1'b0);
        chk("sw_imm", out_imm, 12);
        chk("sw_to_lsb", out_to_lsb, 1);
        chk("sw_to_rs", out_to_rs, 0);
        chk("sw_store", out_is_store, 1);
        chk("sw_rd_valid", out_rd_valid, 0);
        chk("sw_func3", out_func3, 2);
        chk("sw_rs1_data", out_rs1_data, 32'h1000);
        chk("sw_rs2_data", out_rs2_data, 32'hABC);
        send(32'h123452B7, 32'h808, 1'b0);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", out_rd, 5);
        rdy = 1'b0;
        tick;
        chk("rdy_hold_valid", out_valid, 1);
        chk("rdy_hold_imm", out_imm, 32'h12345000);
        rdy = 1'b1;
        send(32'h008000EF, 32'h80C, 1'b1);
        chk("jal_imm", out_imm, 8);
        chk("jal_branch", out_is_branch, 1);
        chk("jal_pred", out_predict_jump, 1);
        send(32'hFFF0007F, 32'h810, 1'b0);
        chk("unk_imm", out_imm, 0);
        chk("unk_rd_valid", out_rd_valid, 1);
        chk("unk_to_rs", out_to_rs, 1);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised decode stage between ifetch and the RS/LSB dispatch.
- Buffers fetched instructions in a BUF_DEPTH FIFO and decodes the head.
- Resolves operands from regfile, ROB and CDB_N broadcast channels, then holds one decoded packet in an output register until dispatch accepts it.
- New capability: while a packet is stalled, it keeps snooping all CDB channels so pending operands resolve in place. Rollback flushes the whole stage.

Parameters:
- BUF_DEPTH, 4, instruction FIFO entries; power of 2, ≥2.
- CDB_N, 2, number of result broadcast channels (ALU, LSB, ...).
- ROB_ID_W, 4, ROB index width.
- DATA_W, 32, data/address/instruction width.

Ports:
- clk in 1: clock.
- rst in 1: synchronous reset, active-low.
- rdy in 1: global enable; low freezes all state.
- rollback in 1: flush.
- inst_valid in 1: fetch offer.
- inst in DATA_W: instruction word.
- inst_pc in DATA_W: instruction PC.
- inst_predict_jump in 1: branch prediction bit.
- inst_ready out 1: FIFO not full.
- rf_rs1 out 5, rf_rs2 out 5: regfile read indices (comb, from FIFO head).
- rf_rs1_data in DATA_W, rf_rs1_busy in 1, rf_rs1_rob_id in ROB_ID_W: rs1 regfile answer; same trio for rs2.
- rob_q1_id out ROB_ID_W, rob_q1_ready in 1, rob_q1_data in DATA_W: rs1 ROB query; same trio (q2) for rs2.
- rob_alloc_id in ROB_ID_W: ROB tag for the next packet.
- cdb_valid in CDB_N, cdb_rob_id in CDB_N*ROB_ID_W, cdb_data in CDB_N*DATA_W: flattened broadcast channels.
- out_valid out 1, out_ready in 1: packet handshake; fire = both high.
- out_to_rs out 1, out_to_lsb out 1: destination select.
- out_opcode out 7, out_func3 out 3, out_func1 out 1: decoded fields.
- out_rs1_dep out 1, out_rs1_rob_id out ROB_ID_W, out_rs1_data out DATA_W: rs1 operand; same trio for rs2.
- out_rd_valid out 1, out_rd out 5, out_rd_rob_id out ROB_ID_W: destination.
- out_imm out DATA_W: immediate (LUI/AUIPC/I/L/S) or offset (JAL/B).
- out_pc out DATA_W, out_is_branch out 1, out_predict_jump out 1, out_is_store out 1: control info.

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO pointers and count cleared; out_valid=0.
  - All out_* data fields 0; inst_ready=1 on the following cycle.
- rdy=0: no state changes; comb outputs still driven.
- FIFO:
  - Push when inst_valid && inst_ready.
  - Pop when head present && (!out_valid || fire).
  - Push and pop in the same cycle are allowed at full and at empty (an empty FIFO cannot pop; the pushed entry stays).
  - Pointers wrap modulo BUF_DEPTH.
- Decode (comb on head) latches into the output register on pop. Minimum latency: accept at edge t, out_valid high after edge t+1.
- Opcode classes:
  - rs1 used by ARITH/S/B/ARITHI/L; rs2 by ARITH/S/B.
  - rd_valid=0 for S/B, 1 otherwise.
  - S/L → to_lsb, else to_rs. JAL/B/JALR → is_branch. S → is_store.
- Immediates:
  - LUI/AUIPC: {inst[31:12], 12'b0}.
  - JAL: sign-extended {31,19:12,20,30:21,0}.
  - B: sign-extended {31,7,30:25,11:8,0}.
  - I/L/JALR: sext inst[31:20].
  - S: sext {31:25,11:7}.
- Operand resolution at latch, priority:
  - Unused register or x0: dep=0, data=0.
  - !busy: regfile data.
  - rob_q ready: ROB data.
  - CDB match, lowest index wins.
  - Otherwise dep=1, rob_id=rf rob_id.
- rob_q*_id = rf_rs*_rob_id (comb).
- Hold: while out_valid && !out_ready, any pending operand whose rob_id matches a valid CDB channel captures that data and clears dep at the next edge. Both operands may capture in the same cycle.
- out_rd_rob_id = rob_alloc_id sampled at latch.
- rollback=1 at an edge (has priority over all else):
  - FIFO emptied, out_valid=0, concurrent push dropped.
  - inst_ready is high again on the next cycle.
- Unknown opcode: decoded as to_rs with rd_valid=1, imm=0. The RS treats it as a nop.

Decomposition:
- Shared const package: OPCODE_* codes, field ranges (OPCODE/FUNC3/FUNC1/RS1/RS2/RD), DATA_W/ROB_ID_W defaults.
- Natural sub-module: inst_fifo (parametrised BUF_DEPTH×(DATA_W+DATA_W+1) sync FIFO with count, full/empty).
- The decode/immediate logic stays in decode_stage as combinational functions.

Test Plan:
- Reset, then push ADDI x5,x0,7 (0x00700293) at pc 0x100, out_ready=1 → out_valid after 2 edges; imm=7, rs1_dep=0, rs1_data=0, rd=5, to_rs=1.
- Fill: out_ready=0, push 5 instrs with BUF_DEPTH=4 → inst_ready=0 after the 4th FIFO entry (1 in out reg + 4 buffered). Raise out_ready → all 5 emerge in order with no bubbles.
- Stall capture: ADD with rs1 busy rob_id=3 and ROB not ready, out_ready=0; cdb ch1 valid, id 3, data 0xDEAD → next cycle rs1_dep=0, rs1_data=0xDEAD.
- Same-cycle CDB bypass at latch: rs2 busy rob_id=2, cdb ch0 id 2 data 0x55 during the pop cycle → packet shows rs2_dep=0, data 0x55.
- Rollback with FIFO holding 3 entries plus a concurrent push → next cycle out_valid=0, FIFO empty, inst_ready=1; the dropped instruction never appears.
- Immediates: BEQ 0xFE000EE3 → imm=0xFFFFFFFC, is_branch=1, rd_valid=0; SW 0x00112623 → imm=12, to_lsb=1, is_store=1.
